// File: rtl/prog_counter_if.sv
// rtl/prog_counter_if.sv - control and status bundle for the programmable counter
//
// Groups every non-clock, non-reset signal of prog_counter.
//   master : drives en, up_dn, mode, max_val, prescale, load, load_val, out_en;
//            observes count, count_out, count_oe, tc, done
//   slave  : the counter side (directions reversed)
interface prog_counter_if #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 8
);
    logic             en;
    logic             up_dn;
    logic [1:0]       mode;
    logic [WIDTH-1:0] max_val;
    logic [PSC_W-1:0] prescale;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             out_en;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_out;
    logic [WIDTH-1:0] count_oe;
    logic             tc;
    logic             done;

    modport master (
        output en, up_dn, mode, max_val, prescale, load, load_val, out_en,
        input  count, count_out, count_oe, tc, done
    );

    modport slave (
        input  en, up_dn, mode, max_val, prescale, load, load_val, out_en,
        output count, count_out, count_oe, tc, done
    );
endinterface

// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - prescaled up/down counter with wrap, saturate and one-shot modes
//
// Ports:
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus.en     : count enable (prescaler and counter hold when low)
//   bus.up_dn  : 1 = increment, 0 = decrement
//   bus.mode   : 00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   bus.max_val: up-direction terminal value / down-direction reload value
//   bus.prescale : counter advances once every prescale+1 enabled cycles
//   bus.load, bus.load_val : synchronous load, highest priority
//   bus.out_en : gates count_out, replicated onto count_oe
//   bus.count  : registered count (ungated)
//   bus.count_out, bus.count_oe : gated count and output-enable vector
//   bus.tc     : one-cycle pulse after any step taken at the terminal
//   bus.done   : sticky one-shot completion flag
module prog_counter #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    prog_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic tick;
    logic one_shot;
    logic saturate;
    logic at_term;
    logic step;

    always_comb begin
        tick     = (psc_q == bus.prescale);
        one_shot = (bus.mode == 2'b10);
        saturate = (bus.mode == 2'b01);
        // Up terminal uses >= so a loaded value above max_val terminates on the next step.
        at_term  = bus.up_dn ? (count_q >= bus.max_val) : (count_q == '0);
        // A finished one-shot freezes the counter until load or reset.
        step     = bus.en && tick && !bus.load && !(one_shot && done_q);

        psc_d   = psc_q;
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;

        if (bus.load) begin
            psc_d   = '0;
            count_d = bus.load_val;
            done_d  = 1'b0;
        end else begin
            if (bus.en) begin
                psc_d = tick ? '0 : psc_q + PSC_ONE;
            end
            if (step) begin
                tc_d = at_term;
                if (at_term) begin
                    if (!saturate) begin
                        count_d = bus.up_dn ? '0 : bus.max_val;
                    end
                    if (one_shot) begin
                        done_d = 1'b1;
                    end
                end else begin
                    count_d = bus.up_dn ? count_q + CNT_ONE : count_q - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            psc_q   <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            psc_q   <= psc_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.count_out = bus.out_en ? count_q : '0;
    assign bus.count_oe  = {WIDTH{bus.out_en}};
    assign bus.tc        = tc_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_prog_counter.sv
// tb/tb_prog_counter.sv - directed self-checking bench for prog_counter
module tb_prog_counter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    prog_counter_if #(.WIDTH(8), .PSC_W(8)) bus ();

    prog_counter #(.WIDTH(8), .PSC_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edge_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] val);
        bus.load     = 1'b1;
        bus.load_val = val;
        edge_clk();
        bus.load     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.up_dn    = 1'b1;
        bus.mode     = 2'b00;
        bus.max_val  = 8'd5;
        bus.prescale = 8'd0;
        bus.load     = 1'b0;
        bus.load_val = 8'd0;
        bus.out_en   = 1'b0;
        #3;
        chk8("reset_count", bus.count, 8'h00);
        chk1("reset_tc", bus.tc, 1'b0);
        chk1("reset_done", bus.done, 1'b0);
        chk8("reset_count_oe_off", bus.count_oe, 8'h00);
        bus.out_en = 1'b1;
        #1;
        chk8("reset_count_oe_on", bus.count_oe, 8'hFF);
        chk8("reset_count_out", bus.count_out, 8'h00);
    endtask

    task automatic test_wrap_up();
        logic [7:0] exp_cnt [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
        logic       exp_tc  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        edge_clk();
        bus.en = 1'b1;
        rst_n  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            edge_clk();
            chk8($sformatf("wrap_up_count[%0d]", i), bus.count, exp_cnt[i]);
            chk1($sformatf("wrap_up_tc[%0d]", i), bus.tc, exp_tc[i]);
        end
        chk8("wrap_up_count_out", bus.count_out, 8'd1);
    endtask

    task automatic test_wrap_down();
        bus.up_dn = 1'b0;
        bus.max_val = 8'd5;
        do_load(8'd1);
        edge_clk();
        chk8("wrap_down_to_0", bus.count, 8'd0);
        chk1("wrap_down_tc0", bus.tc, 1'b0);
        edge_clk();
        chk8("wrap_down_reload", bus.count, 8'd5);
        chk1("wrap_down_tc1", bus.tc, 1'b1);
        bus.up_dn = 1'b1;
    endtask

    task automatic test_prescale();
        logic       en_v [13] = '{1,1,1,1,1,1,1,0,0,0,0,1,1};
        logic [7:0] exp  [13] = '{0,0,1,1,1,2,2,2,2,2,2,2,3};
        bus.mode     = 2'b00;
        bus.up_dn    = 1'b1;
        bus.max_val  = 8'd255;
        bus.prescale = 8'd2;
        do_load(8'd0);
        for (int i = 0; i < 13; i++) begin
            bus.en = en_v[i];
            edge_clk();
            chk8($sformatf("prescale_count[%0d]", i), bus.count, exp[i]);
        end
        bus.en       = 1'b1;
        bus.prescale = 8'd0;
    endtask

    task automatic test_saturate_down();
        logic [7:0] exp_cnt [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
        logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        bus.mode  = 2'b01;
        bus.up_dn = 1'b0;
        do_load(8'd2);
        chk8("sat_loaded", bus.count, 8'd2);
        chk1("sat_load_tc", bus.tc, 1'b0);
        for (int i = 0; i < 4; i++) begin
            edge_clk();
            chk8($sformatf("sat_count[%0d]", i), bus.count, exp_cnt[i]);
            chk1($sformatf("sat_tc[%0d]", i), bus.tc, exp_tc[i]);
        end
        bus.up_dn = 1'b1;
    endtask

    task automatic test_one_shot();
        logic [7:0] exp_cnt  [6] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0};
        logic       exp_tc   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       exp_done [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bus.mode    = 2'b10;
        bus.max_val = 8'd3;
        do_load(8'd0);
        for (int i = 0; i < 6; i++) begin
            edge_clk();
            chk8($sformatf("oneshot_count[%0d]", i), bus.count, exp_cnt[i]);
            chk1($sformatf("oneshot_tc[%0d]", i), bus.tc, exp_tc[i]);
            chk1($sformatf("oneshot_done[%0d]", i), bus.done, exp_done[i]);
        end
        do_load(8'd1);
        chk8("oneshot_reload_count", bus.count, 8'd1);
        chk1("oneshot_reload_done", bus.done, 1'b0);
        edge_clk();
        chk8("oneshot_resume", bus.count, 8'd2);
    endtask

    task automatic test_load_at_terminal();
        bus.mode    = 2'b10;
        bus.max_val = 8'd5;
        do_load(8'd5);
        bus.load     = 1'b1;
        bus.load_val = 8'd9;
        edge_clk();
        bus.load     = 1'b0;
        chk8("load_term_count", bus.count, 8'd9);
        chk1("load_term_tc", bus.tc, 1'b0);
        chk1("load_term_done", bus.done, 1'b0);
        bus.mode = 2'b00;
        edge_clk();
        chk8("above_max_wraps", bus.count, 8'd0);
        chk1("above_max_tc", bus.tc, 1'b1);
    endtask

    task automatic test_async_reset();
        bus.mode     = 2'b11;
        bus.max_val  = 8'd255;
        bus.prescale = 8'd2;
        bus.out_en   = 1'b1;
        do_load(8'h79);
        for (int i = 0; i < 3; i++) edge_clk();
        chk8("pre_reset_count", bus.count, 8'h7A);
        edge_clk();
        #2;
        rst_n = 1'b0;
        #1;
        chk8("async_count", bus.count, 8'h00);
        chk8("async_count_out", bus.count_out, 8'h00);
        chk1("async_tc", bus.tc, 1'b0);
        chk1("async_done", bus.done, 1'b0);
        chk8("async_count_oe_on", bus.count_oe, 8'hFF);
        bus.out_en = 1'b0;
        #1;
        chk8("async_count_out_off", bus.count_out, 8'h00);
        chk8("async_count_oe_off", bus.count_oe, 8'h00);
        bus.out_en = 1'b1;
        edge_clk();
        rst_n = 1'b1;
        edge_clk();
        chk8("post_reset_e1", bus.count, 8'h00);
        edge_clk();
        chk8("post_reset_e2", bus.count, 8'h00);
        edge_clk();
        chk8("post_reset_e3", bus.count, 8'h01);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_prescale();
        test_saturate_down();
        test_one_shot();
        test_load_at_terminal();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
